lb_uart_rx_core: RTL
====================

# lb_uart_rx_core

UART receive core, the receive-side counterpart of the `lb_UART_Tx_Core` transmitter. It recovers frames from the serial line and presents the received byte with parity and framing status to the local-bus peripheral logic. It uses the same per-bit clock count and frame-format controls as the transmitter, so one configuration register set serves both directions.

## Interface
Parameters: none; all frame configuration is runtime.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial line, idle high.
- `baud_value` in 20: clock cycles per bit period; values 0–3 are treated as 4.
- `bit8` in 1: 1 = 8 data bits; 0 = 7 data bits.
- `parity_en` in 1: a parity bit follows the data bits.
- `odd_n_even` in 1: 1 = odd parity; 0 = even parity.
- `cs` in 1: receiver enable; 0 holds the core in IDLE.
- `data` out 8: last received character; in 7-bit mode `data[7]` is 0.
- `rx_done` out 1: one-cycle pulse when `data` and the error flags update.
- `parity_err` out 1: parity mismatch on the last frame; 0 when `parity_en` = 0.
- `frame_err` out 1: the stop bit of the last frame was sampled as 0.
- `rx_busy` out 1: high in every state except IDLE.

## Operation
- Frame on the line, LSB first: start bit (0), data[0..6], data[7] only if `bit8`, parity only if `parity_en`, one stop bit (1).
- Parity:
  - Even parity: the parity bit equals the XOR of the data bits.
  - Odd parity: the parity bit is the inverse of that XOR.
  - Only the received data bits are covered (7 or 8 of them).
- `rx` passes through a 2-flop synchronizer (reset value 1). A falling edge is a synchronized 1 followed by a synchronized 0.
- `bit8`, `parity_en`, `odd_n_even` and `baud_value` are latched at start detection. Changes mid-frame do not affect the frame in progress.
- States:
  - IDLE: a falling edge with `cs` = 1 loads the bit counter and goes to START.
  - START: at the half-bit point (`baud_value >> 1` cycles after the edge), sample `rx`. A 0 goes to DATA. A 1 is a false start: return to IDLE with no `rx_done`.
  - DATA: sample every `baud_value` cycles into the shift register, LSB first. After 7 or 8 bits, go to PARITY if enabled, else to STOP.
  - PARITY: sample one bit and compute the mismatch.
  - STOP: sample one bit, then go to IDLE in the same cycle, without waiting for the end of the stop bit. Output updates are described under Timing.
- After a framing error, IDLE detects a new start only after the line has returned high (edge-based detection), so a held break yields exactly one frame.
- `cs` deasserting in any non-IDLE state aborts the frame: return to IDLE, no `rx_done`, outputs unchanged.

## Timing
- Reset values: `data` = 0x00, `rx_done` = 0, `parity_err` = 0, `frame_err` = 0, `rx_busy` = 0, state = IDLE, synchronizer = 1.
- Latency: a line edge is seen as a falling edge 2 cycles later (synchronizer).
- With B = `baud_value`, measured from the detected edge at cycle t:
  - start-bit sample at t + B/2;
  - bit n sample (n = 1, 2, ...) at t + B/2 + n·B.
- `rx_done` is high in the cycle after the stop sample. `data`, `parity_err` and `frame_err` change in that same cycle and hold until the next `rx_done`.
- `rx_busy` rises the cycle after the edge is detected and falls the cycle after the stop sample.
- Back-to-back frames: a falling edge in the same cycle IDLE is re-entered is detected.
- Reset asserted mid-frame: the next cycle shows reset values and no `rx_done`.

## Structure
- Shared package `lb_uart_pkg` holds:
  - the receiver state enum;
  - constants `UART_MIN_BAUD` = 4, `UART_DATA7` = 7, `UART_DATA8` = 8;
  - a parity helper function usable by both TX and RX.
- One sub-module, `lb_uart_rx_sampler`. It contains the synchronizer, the falling-edge detector and the baud counter, and emits a one-cycle `sample` strobe at each sample point. The core holds the FSM, the shift register and the error logic.

## Test plan
All cases use B = 16 unless noted.
- Even parity, 8-bit: `bit8`=1, `parity_en`=1, `odd_n_even`=0, send 0xA5 with parity bit 0 -> one `rx_done`, `data`=0xA5, `parity_err`=0, `frame_err`=0. The pulse arrives 2 + 8 + 10·16 + 1 cycles after the line falls.
- Odd parity, 7-bit: `bit8`=0, `parity_en`=1, `odd_n_even`=1, send 0x41 with parity bit 1 -> `data`=0x41, `parity_err`=0. The same frame with parity bit 0 -> `parity_err`=1, `data`=0x41.
- Framing error: `bit8`=1, `parity_en`=0, send 0x3C with stop bit 0, then hold the line low for 40 bit times -> exactly one `rx_done`, `frame_err`=1. Then release the line high and send 0x55 -> `data`=0x55, `frame_err`=0.
- Glitch: a 5-cycle low pulse -> no `rx_done`; `rx_busy` returns to 0 once the START sample reads 1.
- Back-to-back and minimum baud: send 0x00 and 0xFF with no idle gap -> two `rx_done` pulses, `data`=0x00 then 0xFF. Repeat with `baud_value`=2 (treated as 4) -> correct reception.
- Aborts:
  - reset at bit 4 of a frame -> all outputs at reset values, no `rx_done`; the next frame is received correctly;
  - `cs`=0 at bit 3 -> no `rx_done`, `data` unchanged.

Source files
------------

// File: rtl/lb_uart_pkg.sv
// Shared UART definitions: receiver states, frame
// constants and parity helper for both TX and RX.
package lb_uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam int unsigned UART_MIN_BAUD = 4;
  localparam int unsigned UART_DATA7    = 7;
  localparam int unsigned UART_DATA8    = 8;

  // Expected parity bit for d; odd=1 selects odd parity.
  function automatic logic uart_parity(
    input logic [7:0] d,
    input logic       odd
  );
    return (^d) ^ odd;
  endfunction

  // Cycles per bit actually used; small values clamp.
  function automatic logic [19:0] uart_eff_baud(
    input logic [19:0] b
  );
    if (b < 20'(UART_MIN_BAUD))
      return 20'(UART_MIN_BAUD);
    return b;
  endfunction

endpackage

// File: rtl/lb_uart_rx_sampler.sv
// RX line front end: 2-flop sync, falling-edge detect,
// baud counter with one-cycle sample strobe.
// Ports: clk, reset, rx (async line), baud_value,
//   load (edge accepted, arm half-bit count),
//   run (frame active), rx_s (synced line),
//   fall (falling edge), sample (sample point strobe).
module lb_uart_rx_sampler
  import lb_uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [19:0] baud_value,
  input  logic        load,
  input  logic        run,
  output logic        rx_s,
  output logic        fall,
  output logic        sample
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        prev_q,  prev_d;
  logic [19:0] baud_q,  baud_d;
  logic [19:0] cnt_q,   cnt_d;
  logic [19:0] eff;

  assign eff = uart_eff_baud(baud_value);

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    baud_d  = baud_q;
    cnt_d   = cnt_q;
    if (load) begin
      // First strobe lands half a bit after the edge.
      baud_d = eff;
      cnt_d  = (eff >> 1) - 20'd1;
    end else if (run) begin
      if (cnt_q == 20'd0)
        cnt_d = baud_q - 20'd1;
      else
        cnt_d = cnt_q - 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      baud_q  <= 20'(UART_MIN_BAUD);
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      baud_q  <= baud_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rx_s   = sync2_q;
  assign fall   = prev_q & ~sync2_q;
  assign sample = run & (cnt_q == 20'd0);

endmodule

// File: rtl/lb_uart_rx_core.sv
// UART receive core: frame FSM, shift register and
// parity/framing error reporting.
// Ports: clk, reset (sync, high), rx, baud_value,
//   bit8, parity_en, odd_n_even, cs (enable);
//   data, rx_done (pulse), parity_err, frame_err,
//   rx_busy.
module lb_uart_rx_core
  import lb_uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [19:0] baud_value,
  input  logic        bit8,
  input  logic        parity_en,
  input  logic        odd_n_even,
  input  logic        cs,
  output logic [7:0]  data,
  output logic        rx_done,
  output logic        parity_err,
  output logic        frame_err,
  output logic        rx_busy
);

  rx_state_e   state_q, state_d;
  logic [2:0]  idx_q,   idx_d;
  logic [7:0]  sh_q,    sh_d;
  logic        b8_q,    b8_d;
  logic        pen_q,   pen_d;
  logic        odd_q,   odd_d;
  logic        pbit_q,  pbit_d;
  logic [7:0]  data_q,  data_d;
  logic        done_q,  done_d;
  logic        perr_q,  perr_d;
  logic        ferr_q,  ferr_d;
  logic        busy_q,  busy_d;

  logic        rx_s;
  logic        fall;
  logic        sample;
  logic        load;
  logic        run;
  logic [2:0]  last_idx;

  assign run  = (state_q != RX_IDLE);
  assign load = (state_q == RX_IDLE) & cs & fall;

  assign last_idx = b8_q ? 3'(UART_DATA8 - 1)
                         : 3'(UART_DATA7 - 1);

  lb_uart_rx_sampler u_sampler (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .baud_value (baud_value),
    .load       (load),
    .run        (run),
    .rx_s       (rx_s),
    .fall       (fall),
    .sample     (sample)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    b8_d    = b8_q;
    pen_d   = pen_q;
    odd_d   = odd_q;
    pbit_d  = pbit_q;
    data_d  = data_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    unique case (state_q)
      RX_IDLE: begin
        if (load) begin
          state_d = RX_START;
          idx_d   = '0;
          // Cleared so 7-bit frames leave bit 7 at 0.
          sh_d    = '0;
          b8_d    = bit8;
          pen_d   = parity_en;
          odd_d   = odd_n_even;
          pbit_d  = 1'b0;
        end
      end
      RX_START: begin
        if (sample)
          state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (sample) begin
          sh_d[idx_q] = rx_s;
          if (idx_q == last_idx)
            state_d = pen_q ? RX_PARITY : RX_STOP;
          else
            idx_d = idx_q + 3'd1;
        end
      end
      RX_PARITY: begin
        if (sample) begin
          pbit_d  = rx_s;
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (sample) begin
          state_d = RX_IDLE;
          done_d  = 1'b1;
          data_d  = sh_q;
          ferr_d  = ~rx_s;
          perr_d  = pen_q &
            (pbit_q != uart_parity(sh_q, odd_q));
        end
      end
      default: state_d = RX_IDLE;
    endcase
    // Disable aborts the frame; results stay as they were.
    if (run && !cs) begin
      state_d = RX_IDLE;
      done_d  = 1'b0;
      data_d  = data_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
    end
    busy_d = (state_d != RX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
      b8_q    <= 1'b0;
      pen_q   <= 1'b0;
      odd_q   <= 1'b0;
      pbit_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      b8_q    <= b8_d;
      pen_q   <= pen_d;
      odd_q   <= odd_d;
      pbit_q  <= pbit_d;
      data_q  <= data_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign data       = data_q;
  assign rx_done    = done_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign rx_busy    = busy_q;

endmodule
